// File: rtl/link_pkg.sv
// link_pkg: constants and state encoding shared by the rotating serializer
// and its receive end (serial_word_capture).
//   LINK_WIDTH   : default word width / bits per frame
//   link_state_t : receiver FSM states (IDLE waits for a frame start,
//                  SHIFT assembles words continuously)
package link_pkg;

    localparam int LINK_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_t;

endpackage

// File: rtl/serial_word_capture_if.sv
// serial_word_capture_if: valid/ready word handshake between the capture
// block (master, produces words) and its consumer (slave).
//   dout       : captured word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer takes dout on an edge where dout_valid is high
interface serial_word_capture_if
    import link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/serial_word_capture.sv
// serial_word_capture: rebuilds parallel words from an MSB-first serial
// stream and presents them over a valid/ready handshake.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   sin         : serial data bit (MSB first)
//   sin_valid   : bit strobe, sin is taken on this edge
//   frame_start : with sin_valid, marks bit 0 (MSB) of a new word
//   out_if      : word handshake (dout / dout_valid / dout_ready)
//   overrun     : sticky, a completed word was dropped while the consumer stalled
//   ovr_clr     : clears overrun (a simultaneous new overrun wins)
//   bit_cnt     : bits accepted into the current word, 0..WIDTH-1
module serial_word_capture
    import link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sin,
    input  logic                         sin_valid,
    input  logic                         frame_start,
    serial_word_capture_if.master        out_if,
    output logic                         overrun,
    input  logic                         ovr_clr,
    output logic [CW-1:0]                bit_cnt
);

    link_state_t      state_reg, state_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             valid_reg, valid_next;
    logic             ovr_reg, ovr_next;

    logic             complete;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] restart_word;
    logic             drop;

    assign word         = {sh_reg[WIDTH-2:0], sin};
    assign restart_word = {{(WIDTH-1){1'b0}}, sin};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            sh_reg    <= '0;
            cnt_reg   <= '0;
            dout_reg  <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sh_reg    <= sh_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
            ovr_reg   <= ovr_next;
        end
    end

    // Framing: a qualified frame_start always restarts the word as bit 0,
    // even on what would otherwise be the completing bit.
    always_comb begin
        state_next = state_reg;
        sh_next    = sh_reg;
        cnt_next   = cnt_reg;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sin_valid && frame_start) begin
                    sh_next    = restart_word;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    if (frame_start) begin
                        sh_next  = restart_word;
                        cnt_next = CW'(1);
                    end else if (cnt_reg == CW'(WIDTH - 1)) begin
                        // Stay in SHIFT: the next strobe is bit 0 of the next word.
                        sh_next  = word;
                        cnt_next = '0;
                        complete = 1'b1;
                    end else begin
                        sh_next  = word;
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: a new word is taken if the slot is empty or is being
    // emptied on this same edge; otherwise it is dropped and flagged.
    always_comb begin
        dout_next  = dout_reg;
        valid_next = valid_reg;
        drop       = 1'b0;
        if (complete) begin
            if (!valid_reg || out_if.dout_ready) begin
                dout_next  = word;
                valid_next = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_reg && out_if.dout_ready) begin
            valid_next = 1'b0;
        end
        if (drop) begin
            ovr_next = 1'b1;
        end else if (ovr_clr) begin
            ovr_next = 1'b0;
        end else begin
            ovr_next = ovr_reg;
        end
    end

    assign out_if.dout       = dout_reg;
    assign out_if.dout_valid = valid_reg;
    assign overrun           = ovr_reg;
    assign bit_cnt           = cnt_reg;

endmodule

// File: tb/tb_serial_word_capture.sv
module tb_serial_word_capture;
    import link_pkg::*;

    localparam int W = LINK_WIDTH;

    logic         clk = 1'b0;
    logic         reset;
    logic         sin;
    logic         sin_valid;
    logic         frame_start;
    logic         overrun;
    logic         ovr_clr;
    logic [2:0]   bit_cnt;

    int checks = 0;
    int errors = 0;

    serial_word_capture_if #(.WIDTH(W)) dout_if ();

    serial_word_capture #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .frame_start (frame_start),
        .out_if      (dout_if.master),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .bit_cnt     (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        sin         = b;
        sin_valid   = 1'b1;
        frame_start = fs;
        tick();
        sin_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends a word MSB first; gap idle cycles follow every bit. With gap>0
    // the bit counter is checked after each strobe and after each gap.
    task automatic send_word(input logic [7:0] data, input logic fs, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(data[i], fs && (i == 7));
            if (gap > 0) chk("gap_cnt_strobe", bit_cnt, (8 - i) % 8);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_cnt_hold", bit_cnt, (8 - i) % 8);
            end
        end
    endtask

    task automatic consume();
        dout_if.dout_ready = 1'b1;
        tick();
        dout_if.dout_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        reset = 1'b1;
        sin = 1'b0;
        sin_valid = 1'b0;
        frame_start = 1'b0;
        ovr_clr = 1'b0;
        dout_if.dout_ready = 1'b0;

        // Reset holds everything while 8 bits are driven
        send_word(8'hFF, 1'b1, 0);
        chk("rst_dout", dout_if.dout, 8'h00);
        chk("rst_valid", dout_if.dout_valid, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_cnt", bit_cnt, 3'd0);
        reset = 1'b0;
        tick();

        // IDLE ignores strobes without frame_start
        send_bit(1'b1, 1'b0);
        chk("idle_ignore_cnt", bit_cnt, 3'd0);

        // Basic word, consumer stalled
        send_word(8'hA5, 1'b1, 0);
        chk("basic_dout", dout_if.dout, 8'hA5);
        chk("basic_valid", dout_if.dout_valid, 1'b1);
        chk("basic_cnt", bit_cnt, 3'd0);
        repeat (3) tick();
        chk("basic_hold_dout", dout_if.dout, 8'hA5);
        chk("basic_hold_valid", dout_if.dout_valid, 1'b1);
        consume();
        chk("basic_consumed", dout_if.dout_valid, 1'b0);
        consume();
        chk("ready_no_valid", dout_if.dout_valid, 1'b0);

        // Gapped stream (still in SHIFT, so frame_start acts as resync)
        send_word(8'h3C, 1'b1, 2);
        chk("gap_dout", dout_if.dout, 8'h3C);
        chk("gap_valid", dout_if.dout_valid, 1'b1);
        consume();

        // Back-to-back with consumer ready
        dout_if.dout_ready = 1'b1;
        send_word(8'h81, 1'b1, 0);
        chk("b2b_first_dout", dout_if.dout, 8'h81);
        chk("b2b_first_valid", dout_if.dout_valid, 1'b1);
        dout_if.dout_ready = 1'b0;
        send_bit(1'b0, 1'b0);
        dout_if.dout_ready = 1'b1;
        chk("b2b_mid_cnt", bit_cnt, 3'd1);
        pat = 8'h7E;
        for (int i = 6; i >= 0; i--) send_bit(pat[i], 1'b0);
        dout_if.dout_ready = 1'b0;
        chk("b2b_second_dout", dout_if.dout, 8'h7E);
        chk("b2b_second_valid", dout_if.dout_valid, 1'b1);
        chk("b2b_ovr", overrun, 1'b0);

        // Pass-through: 7E pending, ready rises on the completing edge of 5A
        pat = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(pat[i], 1'b0);
        chk("pt_pending_dout", dout_if.dout, 8'h7E);
        dout_if.dout_ready = 1'b1;
        send_bit(pat[0], 1'b0);
        dout_if.dout_ready = 1'b0;
        chk("pt_dout", dout_if.dout, 8'h5A);
        chk("pt_valid", dout_if.dout_valid, 1'b1);
        chk("pt_ovr", overrun, 1'b0);
        consume();

        // Overrun
        send_word(8'h11, 1'b1, 0);
        send_word(8'h22, 1'b0, 0);
        chk("ovr_dout", dout_if.dout, 8'h11);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_valid", dout_if.dout_valid, 1'b1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr_flag", overrun, 1'b0);
        chk("ovr_clr_dout", dout_if.dout, 8'h11);

        // Clear and new overrun on the same edge: set wins
        pat = 8'h33;
        for (int i = 7; i >= 1; i--) send_bit(pat[i], 1'b0);
        ovr_clr = 1'b1;
        send_bit(pat[0], 1'b0);
        ovr_clr = 1'b0;
        chk("ovr_setwins", overrun, 1'b1);
        chk("ovr_setwins_dout", dout_if.dout, 8'h11);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        consume();

        // Resync after 5 bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("resync_cnt5", bit_cnt, 3'd5);
        send_word(8'hC3, 1'b1, 0);
        chk("resync_dout", dout_if.dout, 8'hC3);
        chk("resync_valid", dout_if.dout_valid, 1'b1);
        chk("resync_ovr", overrun, 1'b0);
        consume();

        // Resync on a completion edge: partial word dropped
        for (int i = 0; i < 7; i++) send_bit(1'b1, (i == 0));
        pat = 8'h96;
        send_bit(pat[7], 1'b1);
        chk("resync_edge_cnt", bit_cnt, 3'd1);
        chk("resync_edge_valid", dout_if.dout_valid, 1'b0);
        for (int i = 6; i >= 0; i--) send_bit(pat[i], 1'b0);
        chk("resync_edge_dout", dout_if.dout, 8'h96);
        chk("resync_edge_ovr", overrun, 1'b0);

        // Reset with a pending word and mid-word
        for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", dout_if.dout_valid, 1'b0);
        chk("rst_mid_dout", dout_if.dout, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_mid_novalid", dout_if.dout_valid, 1'b0);
        chk("rst_mid_cnt", bit_cnt, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
